// File: rtl/stage_1_fetch_pkg.sv
// stage_1_fetch_pkg: shared types and constants for the fetch stage
package stage_1_fetch_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic bool_t;
    typedef struct packed {
        addr_t pc;
        data_t instr;
    } fetch_entry_t;
    localparam data_t NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/stage_1_fetch_if.sv
// stage_1_fetch_if: instruction-memory request/response channel
interface stage_1_fetch_if;
    import stage_1_fetch_pkg::*;
    bool_t imem_req_valid;
    bool_t imem_req_ready;
    addr_t imem_req_addr;
    bool_t imem_resp_valid;
    data_t imem_resp_data;
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data
    );
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data
    );
endinterface

// File: rtl/stage_1_fetch_fifo.sv
// stage_1_fetch_fifo: small in-order queue with flush, used for fetched words and in-flight PCs
module stage_1_fetch_fifo
    import stage_1_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type T = fetch_entry_t,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              push_data,
    output T              head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    T mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign empty  = count == '0;
    assign full   = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];
    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= push_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? nxt(wr_ptr) : wr_ptr;
            rd_ptr <= do_pop ? nxt(rd_ptr) : rd_ptr;
            count  <= count + CW'(push) - CW'(do_pop);
        end
    end
    // The credit scheme upstream must make this unreachable
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));
endmodule

// File: rtl/stage_1_fetch.sv
// stage_1_fetch: PC generation, credit-limited imem reads and an in-order fetch queue
// feeding decode one {instruction, pc, discard} triple per cycle.
module stage_1_fetch
    import stage_1_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000,
    parameter int    DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_in,
    input  logic                   redirect_enable,
    input  addr_t                  redirect_addr,
    stage_1_fetch_if.master        imem,
    output data_t                  instruction_out,
    output addr_t                  pc_out,
    output bool_t                  discard_out
);
    localparam int CW = $clog2(DEPTH + 1);
    addr_t pc, resp_pc;
    logic [CW-1:0] drop, n_out, n_q;
    fetch_entry_t head, resp_entry;
    logic q_empty, q_full, pcq_full, pcq_empty;
    logic fire, resp_ok, bypass, push, pop;
    logic unused_ok;
    assign imem.imem_req_valid = rst_n && (n_out + n_q < CW'(DEPTH)) && !redirect_enable;
    assign imem.imem_req_addr  = pc;
    assign fire       = imem.imem_req_valid && imem.imem_req_ready;
    assign resp_ok    = imem.imem_resp_valid && drop == '0;
    assign bypass     = !redirect_enable && !stall_in && q_empty && resp_ok;
    assign push       = resp_ok && !redirect_enable && !bypass;
    assign pop        = !redirect_enable && !stall_in && !q_empty;
    assign resp_entry = '{pc: resp_pc, instr: imem.imem_resp_data};
    assign unused_ok  = q_full ^ pcq_full ^ pcq_empty;
    stage_1_fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_resp_q (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(redirect_enable),
        .push_data(resp_entry), .head(head), .full(q_full), .empty(q_empty), .count(n_q)
    );
    // Every response pops its request PC, dropped or not, so the FIFO stays aligned
    stage_1_fetch_fifo #(.DEPTH(DEPTH), .T(addr_t)) u_pc_q (
        .clk(clk), .rst_n(rst_n), .push(fire), .pop(imem.imem_resp_valid), .flush(1'b0),
        .push_data(pc), .head(resp_pc), .full(pcq_full), .empty(pcq_empty), .count(n_out)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc              <= RESET_PC;
            drop            <= '0;
            instruction_out <= NOP_INSTR;
            pc_out          <= RESET_PC;
            discard_out     <= 1'b1;
        end else begin
            pc   <= redirect_enable ? {redirect_addr[31:2], 2'b00} : fire ? pc + 32'd4 : pc;
            drop <= redirect_enable ? n_out - CW'(imem.imem_resp_valid)
                                    : drop - CW'(imem.imem_resp_valid && drop != '0);
            if (redirect_enable) begin
                instruction_out <= NOP_INSTR;
                discard_out     <= 1'b1;
            end else if (!stall_in) begin
                instruction_out <= !q_empty ? head.instr : bypass ? imem.imem_resp_data : NOP_INSTR;
                pc_out          <= !q_empty ? head.pc : bypass ? resp_pc : pc_out;
                discard_out     <= q_empty && !bypass;
            end
        end
    end
endmodule
